// File: rtl/tim_arbiter_pkg.sv
// Package tim_arb_wires: request record, port identifiers and the idle request
// shared by the tim arbiter and its pending-slot sub-module.
package tim_arb_wires;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } tim_arb_port_e;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } tim_arb_req_type;

  localparam tim_arb_req_type init_req = '0;

endpackage

// File: rtl/tim_arbiter_slot.sv
// tim_arb_slot: one-entry pending request register for a port that lost
// arbitration.
//  clock, reset : clock; synchronous active-low reset (empties the slot)
//  load         : capture req_in (marked valid)
//  clear        : drop the held request (it was granted this cycle)
//  req_in       : live request to capture
//  full         : slot holds a request
//  req_out      : held request (init_req when empty)
module tim_arb_slot
  import tim_arb_wires::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  tim_arb_req_type req_in,
  output logic            full,
  output tim_arb_req_type req_out
);

  tim_arb_req_type slot_d, slot_q;

  always_comb begin
    slot_d = slot_q;
    if (clear) begin
      slot_d = init_req;
    end
    if (load) begin
      slot_d       = req_in;
      slot_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_q <= init_req;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign full    = slot_q.valid;
  assign req_out = slot_q;

endmodule

// File: rtl/tim_arbiter.sv
// tim_arbiter: shares the single-port tim between the fetch (i) and
// load/store (d) ports. One request is forwarded per cycle with zero added
// issue latency; the loser is held in its pending slot. The response one
// cycle later is routed to the port recorded in the owner register.
//  clock, reset        : clock; synchronous active-low reset
//  i_* / d_*           : requester ports (valid, instr, addr, wdata, wstrb in;
//                        rdata, ready out)
//  tim_*               : forwarded request out; tim_rdata/tim_ready in
// Build option: TIM_ARB_RR_EN selects round-robin arbitration; otherwise d has
// fixed priority and MAX_WAIT bounds how long a waiting i request can lose.
module tim_arbiter
  import tim_arb_wires::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic        i_instr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_valid,
  input  logic        d_instr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        tim_valid,
  output logic        tim_instr,
  output logic [31:0] tim_addr,
  output logic [31:0] tim_wdata,
  output logic [3:0]  tim_wstrb,
  input  logic [31:0] tim_rdata,
  input  logic        tim_ready
);

  tim_arb_req_type i_live, d_live, i_slot, d_slot, i_cand, d_cand, tim_req;
  logic            i_full, d_full, i_busy, d_busy, i_accept, d_accept;
  logic            grant_i, grant_d;
  logic            own_v_d, own_v_q;
  tim_arb_port_e   own_id_d, own_id_q;

  // A port with an access in flight or a request already buffered may not
  // present a new one; such a pulse is dropped.
  assign i_busy   = own_v_q && (own_id_q == PORT_I);
  assign d_busy   = own_v_q && (own_id_q == PORT_D);
  assign i_accept = i_valid && !i_full && !i_busy;
  assign d_accept = d_valid && !d_full && !d_busy;

  always_comb begin
    i_live = '{valid: i_accept, instr: i_instr, addr: i_addr, wdata: i_wdata, wstrb: i_wstrb};
    d_live = '{valid: d_accept, instr: d_instr, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
    i_cand = i_full ? i_slot : (i_accept ? i_live : init_req);
    d_cand = d_full ? d_slot : (d_accept ? d_live : init_req);
  end

`ifdef TIM_ARB_RR_EN
  tim_arb_port_e rr_last_d, rr_last_q;

  always_comb begin
    grant_d   = d_cand.valid && (!i_cand.valid || (rr_last_q == PORT_I));
    grant_i   = i_cand.valid && !grant_d;
    rr_last_d = rr_last_q;
    if (grant_i) begin
      rr_last_d = PORT_I;
    end else if (grant_d) begin
      rr_last_d = PORT_D;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_last_q <= PORT_I;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
  logic [3:0] wait_cnt_d, wait_cnt_q;

  always_comb begin
    grant_d    = d_cand.valid && !(i_cand.valid && (wait_cnt_q == MAX_W));
    grant_i    = i_cand.valid && !grant_d;
    wait_cnt_d = wait_cnt_q;
    if (grant_i) begin
      wait_cnt_d = '0;
    end else if (i_cand.valid && (wait_cnt_q != MAX_W)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // Nothing is forwarded while reset is held.
  always_comb begin
    tim_req = init_req;
    if (reset) begin
      if (grant_d) begin
        tim_req = d_cand;
      end else if (grant_i) begin
        tim_req = i_cand;
      end
    end
    own_v_d  = tim_req.valid;
    own_id_d = grant_d ? PORT_D : PORT_I;
  end

  assign tim_valid = tim_req.valid;
  assign tim_instr = tim_req.instr;
  assign tim_addr  = tim_req.addr;
  assign tim_wdata = tim_req.wdata;
  assign tim_wstrb = tim_req.wstrb;

  tim_arb_slot u_slot_i (
    .clock   (clock),
    .reset   (reset),
    .load    (i_accept && !grant_i),
    .clear   (i_full && grant_i),
    .req_in  (i_live),
    .full    (i_full),
    .req_out (i_slot)
  );

  tim_arb_slot u_slot_d (
    .clock   (clock),
    .reset   (reset),
    .load    (d_accept && !grant_d),
    .clear   (d_full && grant_d),
    .req_in  (d_live),
    .full    (d_full),
    .req_out (d_slot)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      own_v_q  <= 1'b0;
      own_id_q <= PORT_I;
    end else begin
      own_v_q  <= own_v_d;
      own_id_q <= own_id_d;
    end
  end

  // Reset gating also discards a response that was in flight when reset hit.
  assign i_ready = reset && tim_ready && i_busy;
  assign d_ready = reset && tim_ready && d_busy;
  assign i_rdata = i_ready ? tim_rdata : '0;
  assign d_rdata = d_ready ? tim_rdata : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(tim_ready && !own_v_q));
      assert (!(i_valid && (i_full || i_busy)));
      assert (!(d_valid && (d_full || d_busy)));
    end
  end

endmodule

// File: tb/tb_tim_arbiter.sv
module tb_tim_arbiter;

  localparam int unsigned MAX_WAIT = 4;
  localparam int          BIG      = 32'h7fff_ffff;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_valid, i_instr, i_ready;
  logic [31:0] i_addr, i_wdata, i_rdata;
  logic [3:0]  i_wstrb;
  logic        d_valid, d_instr, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        tim_valid, tim_instr, tim_ready;
  logic [31:0] tim_addr, tim_wdata, tim_rdata;
  logic [3:0]  tim_wstrb;

  tim_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .i_valid(i_valid), .i_instr(i_instr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_wstrb(i_wstrb), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_instr(d_instr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ready(d_ready),
    .tim_valid(tim_valid), .tim_instr(tim_instr), .tim_addr(tim_addr),
    .tim_wdata(tim_wdata), .tim_wstrb(tim_wstrb), .tim_rdata(tim_rdata),
    .tim_ready(tim_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;
  typedef struct { int cyc; logic [31:0] data; } rsp_t;
  typedef struct { int cyc; req_t r; } tq_t;

  rsp_t rq_i[$], rq_d[$];
  tq_t  tq[$];
  int   checks = 0, errors = 0, cyc = 0;

  logic [31:0] env_mem[int unsigned];
  logic [31:0] ref_mem[int unsigned];
  logic        env_rdy = 1'b0;
  logic [31:0] env_data = '0;

  req_t slot_m[2];
  int   busy_until[2];
  int   wcnt, rrl;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input bit env, input logic [31:0] a);
    int unsigned k = a >> 2;
    if (env) return env_mem.exists(k) ? env_mem[k] : init_word(a & ~32'h3);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(a & ~32'h3);
  endfunction

  function automatic void mem_wr(input bit env, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] w = mem_rd(env, a);
    for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
    if (env) env_mem[a >> 2] = w; else ref_mem[a >> 2] = w;
  endfunction

  function automatic req_t mk(input logic instr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] st);
    req_t r;
    r.v = 1'b1; r.instr = instr; r.addr = a; r.wdata = wd; r.wstrb = st;
    return r;
  endfunction

  function automatic req_t rnd_req(input logic instr);
    logic [3:0] st;
    st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return mk(instr, 32'h100 + 32'($urandom_range(0, 15)) * 4, $urandom(), st);
  endfunction

  function automatic bit can_issue(input int p);
    return (cyc + 1) > busy_until[p];
  endfunction

  // One clock cycle: present the tim response, drive both ports, then advance
  // the tim environment and the reference model from the spec's rules.
  task automatic step(input bit rst, input bit iv, input req_t ir, input bit dv, input req_t dr);
    req_t cand[2];
    req_t idle;
    int   g;
    tq_t  t;
    rsp_t r;
    @(negedge clock);
    cyc++;
    tim_ready = env_rdy;
    tim_rdata = env_rdy ? env_data : $urandom();
    reset   = ~rst;
    i_valid = iv; i_instr = ir.instr; i_addr = ir.addr; i_wdata = ir.wdata; i_wstrb = ir.wstrb;
    d_valid = dv; d_instr = dr.instr; d_addr = dr.addr; d_wdata = dr.wdata; d_wstrb = dr.wstrb;
    #1;
    env_rdy = tim_valid;
    if (tim_valid) begin
      env_data = mem_rd(1'b1, tim_addr);
      mem_wr(1'b1, tim_addr, tim_wdata, tim_wstrb);
    end
    idle = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    t.cyc = cyc;
    if (rst) begin
      rq_i.delete(); rq_d.delete();
      slot_m[0] = idle; slot_m[1] = idle;
      busy_until[0] = cyc; busy_until[1] = cyc;
      wcnt = 0; rrl = 0;
      t.r = idle;
      tq.push_back(t);
    end else begin
      cand[0] = slot_m[0].v ? slot_m[0] : (iv ? ir : idle);
      cand[1] = slot_m[1].v ? slot_m[1] : (dv ? dr : idle);
      g = -1;
      if (cand[0].v && cand[1].v) begin
`ifdef TIM_ARB_RR_EN
        g = (rrl == 0) ? 1 : 0;
`else
        g = (wcnt == int'(MAX_WAIT)) ? 0 : 1;
`endif
      end else if (cand[0].v) g = 0;
      else if (cand[1].v) g = 1;
`ifdef TIM_ARB_RR_EN
      if (g >= 0) rrl = g;
`else
      if (g == 0) wcnt = 0;
      else if (cand[0].v && wcnt < int'(MAX_WAIT)) wcnt++;
`endif
      t.r = (g >= 0) ? cand[g] : idle;
      tq.push_back(t);
      if (g >= 0) begin
        r.cyc  = cyc + 1;
        r.data = mem_rd(1'b0, cand[g].addr);
        mem_wr(1'b0, cand[g].addr, cand[g].wdata, cand[g].wstrb);
        if (g == 0) rq_i.push_back(r); else rq_d.push_back(r);
        busy_until[g] = cyc + 1;
        slot_m[g] = idle;
      end
      if (iv && g != 0) begin slot_m[0] = ir; busy_until[0] = BIG; end
      if (dv && g != 1) begin slot_m[1] = dr; busy_until[1] = BIG; end
    end
  endtask

  // Monitor: compares DUT outputs with the scoreboard queues each cycle.
  always @(negedge clock) begin : monitor
    tq_t  t;
    rsp_t r;
    logic ev;
    #2;
    if (tq.size() > 0 && tq[0].cyc == cyc) begin
      t = tq.pop_front();
      checks++;
      if ({tim_valid, tim_instr, tim_addr, tim_wdata, tim_wstrb} !==
          {t.r.v, t.r.instr, t.r.addr, t.r.wdata, t.r.wstrb}) begin
        errors++;
        $display("FAIL tim_req cyc %0d got v=%0b i=%0b a=%h wd=%h st=%h exp v=%0b i=%0b a=%h wd=%h st=%h",
                 cyc, tim_valid, tim_instr, tim_addr, tim_wdata, tim_wstrb,
                 t.r.v, t.r.instr, t.r.addr, t.r.wdata, t.r.wstrb);
      end
    end
    if (cyc > 0) begin
      ev = (rq_i.size() > 0 && rq_i[0].cyc == cyc);
      checks++;
      if (i_ready !== ev) begin
        errors++; $display("FAIL i_ready cyc %0d got %0b exp %0b", cyc, i_ready, ev);
      end
      checks++;
      if (ev) begin
        r = rq_i.pop_front();
        if (i_rdata !== r.data) begin
          errors++; $display("FAIL i_rdata cyc %0d got %h exp %h", cyc, i_rdata, r.data);
        end
      end else if (i_rdata !== 32'h0) begin
        errors++; $display("FAIL i_rdata_idle cyc %0d got %h exp 0", cyc, i_rdata);
      end
      ev = (rq_d.size() > 0 && rq_d[0].cyc == cyc);
      checks++;
      if (d_ready !== ev) begin
        errors++; $display("FAIL d_ready cyc %0d got %0b exp %0b", cyc, d_ready, ev);
      end
      checks++;
      if (ev) begin
        r = rq_d.pop_front();
        if (d_rdata !== r.data) begin
          errors++; $display("FAIL d_rdata cyc %0d got %h exp %h", cyc, d_rdata, r.data);
        end
      end else if (d_rdata !== 32'h0) begin
        errors++; $display("FAIL d_rdata_idle cyc %0d got %h exp 0", cyc, d_rdata);
      end
    end
  end

  initial begin : driver
    req_t nr;
    bit   r, iv, dv;
    nr = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    reset = 1'b0;
    i_valid = 1'b0; i_instr = 1'b0; i_addr = '0; i_wdata = '0; i_wstrb = '0;
    d_valid = 1'b0; d_instr = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    tim_ready = 1'b0; tim_rdata = '0;
    busy_until[0] = -1; busy_until[1] = -1;
    slot_m[0] = nr; slot_m[1] = nr; wcnt = 0; rrl = 0;

    repeat (3) step(1'b1, 1'b0, nr, 1'b0, nr);
    // lone fetch read
    step(1'b0, 1'b1, mk(1'b1, 32'h100, 32'h0, 4'h0), 1'b0, nr);
    repeat (2) step(1'b0, 1'b0, nr, 1'b0, nr);
    // contention: d write vs i read
    step(1'b0, 1'b1, mk(1'b1, 32'h204, 32'h0, 4'h0), 1'b1, mk(1'b0, 32'h200, 32'hDEADBEEF, 4'hF));
    repeat (3) step(1'b0, 1'b0, nr, 1'b0, nr);
    // byte write then read back through the other port
    step(1'b0, 1'b0, nr, 1'b1, mk(1'b0, 32'h300, 32'h0000_0012, 4'h1));
    repeat (2) step(1'b0, 1'b0, nr, 1'b0, nr);
    step(1'b0, 1'b1, mk(1'b0, 32'h300, 32'h0, 4'h0), 1'b0, nr);
    repeat (2) step(1'b0, 1'b0, nr, 1'b0, nr);
    // reset the cycle after a grant with i still buffered
    step(1'b0, 1'b1, mk(1'b1, 32'h108, 32'h0, 4'h0), 1'b1, mk(1'b0, 32'h10C, 32'h0, 4'h0));
    step(1'b1, 1'b0, nr, 1'b0, nr);
    repeat (2) step(1'b0, 1'b0, nr, 1'b0, nr);
    // randomized traffic, continuous-pressure bursts and occasional resets
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 249) == 0);
      iv = !r && can_issue(0) && ((n / 500) % 2 == 1 || $urandom_range(0, 9) < 6);
      dv = !r && can_issue(1) && ((n / 500) % 2 == 1 || $urandom_range(0, 9) < 6);
      step(r, iv, rnd_req(1'b1), dv, rnd_req(1'b0));
    end
    repeat (3) step(1'b0, 1'b0, nr, 1'b0, nr);
    #3;
    checks++;
    if (rq_i.size() != 0 || rq_d.size() != 0 || tq.size() != 0) begin
      errors++;
      $display("FAIL drain got i=%0d d=%0d t=%0d outstanding exp 0", rq_i.size(), rq_d.size(), tq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
